// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm - multi-cycle main controller for the MIPS datapath.
//
// Sequences each instruction through IF -> ID -> EX_* -> (MEM_*) -> (WB_*)
// and decodes the datapath controls from the current state (Moore).
// The only combinational input dependencies are pc_we/ir_we on mem_ready
// in IF and pc_we on zero in EX_BR.
//
// Memory handshake: mem_rd/mem_we are held as a request; the access is
// complete in the cycle mem_ready=1, and the FSM leaves the waiting state
// on that edge. All outputs hold steady while waiting.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   op, funct           IR[31:26], IR[5:0] (IR is stable after IF)
//   zero                ALU Z flag (used in EX_BR)
//   mem_ready           memory access completes this cycle
//   pc_we, ir_we        PC / IR write enables
//   i_or_d              memory address select (0 = PC, 1 = ALUOut)
//   mem_rd, mem_we      memory read / write request
//   reg_we, reg_dst     register file write enable, dest select (1 = rd)
//   mem_to_reg          write-back data select (1 = MDR)
//   alu_src_a/b, alu_m  ALU operand selects and mode
//   pc_src              next-PC select
//   illegal             one-cycle pulse in ID on an undecodable instruction
//   halted              controller is in HALT
//   state               current state code, for debug
module mips_ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       i_or_d,
    output logic       mem_rd,
    output logic       mem_we,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [2:0] alu_m,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EX_R   = 4'd2,
        S_EX_I   = 4'd3,
        S_EX_LS  = 4'd4,
        S_EX_BR  = 4'd5,
        S_EX_J   = 4'd6,
        S_MEM_RD = 4'd7,
        S_MEM_WR = 4'd8,
        S_WB_R   = 4'd9,
        S_WB_I   = 4'd10,
        S_WB_LW  = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    state_t r_state;
    state_t w_st;        // state used for output decode
    state_t w_id_next;   // decode result in ID
    logic   w_id_illegal;
    logic   w_en;        // enables are suppressed while in reset

    logic   w_pc_we, w_ir_we, w_mem_rd, w_mem_we, w_reg_we, w_illegal, w_halted;

    // Instruction decode, used for the ID -> EX transition.
    always_comb begin
        w_id_next    = S_IF;
        w_id_illegal = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100000, 6'b100001, 6'b100010, 6'b100100,
                    6'b100101, 6'b101010, 6'b000000, 6'b000010:
                        w_id_next = S_EX_R;
                    default: w_id_illegal = 1'b1;
                endcase
            end
            6'b001000, 6'b001001, 6'b001100, 6'b001101: w_id_next = S_EX_I;
            6'b100011, 6'b101011:                       w_id_next = S_EX_LS;
            6'b000100, 6'b000101:                       w_id_next = S_EX_BR;
            6'b000010:                                  w_id_next = S_EX_J;
            6'b111111:                                  w_id_next = S_HALT;
            default:                                    w_id_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IF;
        end else begin
            case (r_state)
                S_IF:     if (mem_ready) r_state <= S_ID;
                S_ID:     r_state <= w_id_next;
                S_EX_R:   r_state <= S_WB_R;
                S_EX_I:   r_state <= S_WB_I;
                // Only lw/sw reach EX_LS, so checking for sw is sufficient.
                S_EX_LS:  r_state <= (op == 6'b101011) ? S_MEM_WR : S_MEM_RD;
                S_EX_BR:  r_state <= S_IF;
                S_EX_J:   r_state <= S_IF;
                S_MEM_RD: if (mem_ready) r_state <= S_WB_LW;
                S_MEM_WR: if (mem_ready) r_state <= S_IF;
                S_WB_R:   r_state <= S_IF;
                S_WB_I:   r_state <= S_IF;
                S_WB_LW:  r_state <= S_IF;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_IF;
            endcase
        end
    end

    // While rst is high the selects show their IF values and every
    // enable is held low, independent of the register contents.
    assign w_st  = rst ? S_IF : r_state;
    assign w_en  = ~rst;
    assign state = r_state;

    always_comb begin
        w_pc_we    = 1'b0;
        w_ir_we    = 1'b0;
        w_mem_rd   = 1'b0;
        w_mem_we   = 1'b0;
        w_reg_we   = 1'b0;
        w_illegal  = 1'b0;
        w_halted   = 1'b0;
        i_or_d     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 3'b000;
        alu_m      = 3'b000;
        pc_src     = 2'b00;
        case (w_st)
            S_IF: begin
                w_mem_rd  = 1'b1;
                alu_src_b = 3'b001;
                alu_m     = 3'b101;
                // Strobe only on the completing cycle so PC advances once.
                w_pc_we   = mem_ready;
                w_ir_we   = mem_ready;
            end
            S_ID: begin
                alu_src_b = 3'b011;
                alu_m     = 3'b101;
                w_illegal = w_id_illegal;
            end
            S_EX_R: begin
                alu_src_a = ((funct == 6'b000000) || (funct == 6'b000010)) ? 2'b10 : 2'b01;
                case (funct)
                    6'b100000: alu_m = 3'b100;
                    6'b100001: alu_m = 3'b101;
                    6'b100010: alu_m = 3'b110;
                    6'b100100: alu_m = 3'b000;
                    6'b100101: alu_m = 3'b001;
                    6'b101010: alu_m = 3'b011;
                    6'b000000: alu_m = 3'b010;
                    6'b000010: alu_m = 3'b111;
                    default:   alu_m = 3'b100;
                endcase
            end
            S_EX_I: begin
                alu_src_a = 2'b01;
                case (op)
                    6'b001000: begin alu_src_b = 3'b010; alu_m = 3'b100; end
                    6'b001001: begin alu_src_b = 3'b010; alu_m = 3'b101; end
                    6'b001100: begin alu_src_b = 3'b100; alu_m = 3'b000; end
                    default:   begin alu_src_b = 3'b100; alu_m = 3'b001; end
                endcase
            end
            S_EX_LS: begin
                alu_src_a = 2'b01;
                alu_src_b = 3'b010;
                alu_m     = 3'b101;
            end
            S_EX_BR: begin
                alu_src_a = 2'b01;
                alu_m     = 3'b110;
                pc_src    = 2'b01;
                // beq takes the branch on zero, bne on not-zero.
                w_pc_we   = (op == 6'b000101) ? ~zero : zero;
            end
            S_EX_J: begin
                pc_src  = 2'b10;
                w_pc_we = 1'b1;
            end
            S_MEM_RD: begin
                w_mem_rd = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                w_mem_we = 1'b1;
                i_or_d   = 1'b1;
            end
            S_WB_R: begin
                w_reg_we = 1'b1;
                reg_dst  = 1'b1;
            end
            S_WB_I: begin
                w_reg_we = 1'b1;
            end
            S_WB_LW: begin
                w_reg_we   = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_halted = 1'b0;
            end
        endcase
    end

    assign pc_we   = w_en & w_pc_we;
    assign ir_we   = w_en & w_ir_we;
    assign mem_rd  = w_en & w_mem_rd;
    assign mem_we  = w_en & w_mem_we;
    assign reg_we  = w_en & w_reg_we;
    assign illegal = w_en & w_illegal;
    assign halted  = w_en & w_halted;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// tb_mips_ctrl_fsm - directed bench for mips_ctrl_fsm.
// The driver issues one cycle of inputs at a time and pushes the expected
// output vector for that cycle; the monitor pops and compares on the
// falling edge of every cycle that has an expectation queued.
module tb_mips_ctrl_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_we, ir_we, i_or_d, mem_rd, mem_we, reg_we, reg_dst, mem_to_reg;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] alu_m;
    logic [1:0] pc_src;
    logic       illegal, halted;
    logic [3:0] state;

    mips_ctrl_fsm dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .i_or_d(i_or_d),
        .mem_rd(mem_rd), .mem_we(mem_we), .reg_we(reg_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_m(alu_m), .pc_src(pc_src), .illegal(illegal), .halted(halted),
        .state(state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    localparam logic [23:0] FULL = 24'hFFFFFF;
    localparam logic [23:0] NOST = 24'hFFFFF0;  // state field not checked

    logic [47:0] exp_q[$];   // {mask, value}
    string       tag_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [5:0]  cur_op = 6'd0;
    logic [5:0]  cur_fn = 6'd0;

    function automatic logic [23:0] mk(
        input logic pw, iw, iod, mrd, mwe, rwe, rdst, m2r,
        input logic [1:0] a, input logic [2:0] b, input logic [2:0] m,
        input logic [1:0] ps, input logic ill, hlt, input logic [3:0] st);
        return {pw, iw, iod, mrd, mwe, rwe, rdst, m2r, a, b, m, ps, ill, hlt, st};
    endfunction

    // Monitor: one comparison per cycle that has a queued expectation.
    always @(negedge clk) begin
        logic [47:0] e;
        logic [23:0] got;
        string       t;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            got = {pc_we, ir_we, i_or_d, mem_rd, mem_we, reg_we, reg_dst, mem_to_reg,
                   alu_src_a, alu_src_b, alu_m, pc_src, illegal, halted, state};
            total++;
            if ((got & e[47:24]) !== (e[23:0] & e[47:24])) begin
                bad++;
                $display("FAIL %s: got=%h expected=%h (mask %h) state=%0d",
                         t, got, e[23:0], e[47:24], state);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic r, input logic mr, input logic z,
                       input logic [23:0] e, input logic [23:0] m, input string t);
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = mr;
        zero      = z;
        op        = cur_op;
        funct     = cur_fn;
        exp_q.push_back({m, e});
        tag_q.push_back(t);
    endtask

    function automatic logic [23:0] e_if(input logic strobe);
        return mk(strobe, strobe, 0, 1, 0, 0, 0, 0, 2'b00, 3'b001, 3'b101, 2'b00, 0, 0, 4'd0);
    endfunction

    function automatic logic [23:0] e_id(input logic ill);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b011, 3'b101, 2'b00, ill, 0, 4'd1);
    endfunction

    function automatic logic [23:0] e_rst();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b001, 3'b101, 2'b00, 0, 0, 4'd0);
    endfunction

    task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f, input string t);
        cur_op = o;
        cur_fn = f;
        cyc(0, 1, 0, e_if(1'b1), FULL, {t, "_if"});
        cyc(0, 1, 0, e_id(1'b0), FULL, {t, "_id"});
    endtask

    task automatic do_r(input logic [5:0] f, input logic [1:0] a, input logic [2:0] m,
                        input string t);
        fetch_decode(6'b000000, f, t);
        cyc(0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, a, 3'b000, m, 2'b00, 0, 0, 4'd2), FULL, {t, "_ex"});
        cyc(0, 1, 0, mk(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0, 4'd9), FULL, {t, "_wb"});
    endtask

    task automatic do_i(input logic [5:0] o, input logic [2:0] b, input logic [2:0] m,
                        input string t);
        fetch_decode(o, 6'd0, t);
        cyc(0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, b, m, 2'b00, 0, 0, 4'd3), FULL, {t, "_ex"});
        cyc(0, 1, 0, mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0, 4'd10), FULL, {t, "_wb"});
    endtask

    task automatic do_br(input logic [5:0] o, input logic z, input logic pw, input string t);
        fetch_decode(o, 6'd0, t);
        cyc(0, 1, z, mk(pw, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 3'b110, 2'b01, 0, 0, 4'd5), FULL, {t, "_ex"});
    endtask

    task automatic do_ill(input logic [5:0] o, input logic [5:0] f, input string t);
        cur_op = o;
        cur_fn = f;
        cyc(0, 1, 0, e_if(1'b1), FULL, {t, "_if"});
        cyc(0, 1, 0, e_id(1'b1), FULL, {t, "_id"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        op        = 6'd0;
        funct     = 6'd0;
        @(posedge clk);

        // Reset held with memory not ready: IF selects, all enables low.
        cyc(1, 0, 0, e_rst(), FULL, "rst0");
        cyc(1, 0, 0, e_rst(), FULL, "rst1");
        // First cycle after release: fetch request, no strobes yet.
        cyc(0, 0, 0, e_if(1'b0), FULL, "rel_if");

        // R-type
        do_r(6'b100000, 2'b01, 3'b100, "add");
        do_r(6'b000000, 2'b10, 3'b010, "sll");
        do_r(6'b000010, 2'b10, 3'b111, "srl");
        do_r(6'b100010, 2'b01, 3'b110, "sub");
        do_r(6'b101010, 2'b01, 3'b011, "slt");
        do_r(6'b100101, 2'b01, 3'b001, "or");

        // Fetch stall: one wait cycle in IF, then normal I-type.
        cur_op = 6'b001000;
        cyc(0, 0, 0, e_if(1'b0), FULL, "ifstall");
        do_i(6'b001000, 3'b010, 3'b100, "addi");
        do_i(6'b001001, 3'b010, 3'b101, "addiu");
        do_i(6'b001100, 3'b100, 3'b000, "andi");
        do_i(6'b001101, 3'b100, 3'b001, "ori");

        // lw with a 2-cycle stall in MEM_RD
        fetch_decode(6'b100011, 6'd0, "lw");
        cyc(0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 3'b101, 2'b00, 0, 0, 4'd4), FULL, "lw_ex");
        cyc(0, 0, 0, mk(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0, 4'd7), FULL, "lw_mem0");
        cyc(0, 0, 0, mk(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0, 4'd7), FULL, "lw_mem1");
        cyc(0, 1, 0, mk(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0, 4'd7), FULL, "lw_mem2");
        cyc(0, 1, 0, mk(0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0, 4'd11), FULL, "lw_wb");

        // sw
        fetch_decode(6'b101011, 6'd0, "sw");
        cyc(0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 3'b101, 2'b00, 0, 0, 4'd4), FULL, "sw_ex");
        cyc(0, 1, 0, mk(0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0, 4'd8), FULL, "sw_mem");

        // Branches
        do_br(6'b000100, 1'b1, 1'b1, "beq_z1");
        do_br(6'b000101, 1'b1, 1'b0, "bne_z1");
        do_br(6'b000100, 1'b0, 1'b0, "beq_z0");
        do_br(6'b000101, 1'b0, 1'b1, "bne_z0");

        // Jump
        fetch_decode(6'b000010, 6'd0, "j");
        cyc(0, 1, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 2'b10, 0, 0, 4'd6), FULL, "j_ex");

        // Illegal opcode and illegal R-type funct
        do_ill(6'b010000, 6'd0, "ill_op");
        do_ill(6'b000000, 6'b000001, "ill_fn");

        // Reset while waiting in MEM_RD
        fetch_decode(6'b100011, 6'd0, "lwrst");
        cyc(0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 3'b101, 2'b00, 0, 0, 4'd4), FULL, "lwrst_ex");
        cyc(0, 0, 0, mk(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0, 4'd7), FULL, "lwrst_mem");
        cyc(1, 0, 0, e_rst(), NOST, "lwrst_rst");
        cyc(0, 1, 0, e_if(1'b1), FULL, "lwrst_if");

        // Halt: holds for 10 cycles regardless of memory, then reset.
        cur_op = 6'b111111;
        cur_fn = 6'd0;
        cyc(0, 1, 0, e_id(1'b0), FULL, "halt_id");
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1'(i % 2), 0,
                mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 2'b00, 0, 1, 4'd12),
                FULL, "halt_hold");
        end
        cyc(1, 1, 0, e_rst(), NOST, "halt_rst0");
        cyc(1, 1, 0, e_rst(), FULL, "halt_rst1");
        cyc(0, 0, 0, e_if(1'b0), FULL, "halt_rel");

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
